mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_SIZE, default 32'h20000, is the byte size of the data memory behind the arbiter.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 reqN  input  1  request from port N, N in {0,1}; port 0 is the LSU, port 1 is DMA/debug.
REQ-005 weN  input  1  port N write (1) or read (0).
REQ-006 typeN  input  rw_type  port N access size (b/half/word).
REQ-007 addrN  input  32  port N byte address.
REQ-008 wdataN  input  32  port N write data; the size selects the low bytes used.
REQ-009 sextN  input  1  port N sign-extend request for b/half reads.
REQ-010 gntN  output  1  port N request accepted this cycle.
REQ-011 rvalidN  output  1  port N response valid, one cycle after gntN.
REQ-012 rerrN  output  1  port N response error; qualified by rvalidN.
REQ-013 rdataN  output  32  port N read data; qualified by rvalidN and !rerrN.
REQ-014 mem_write_en, mem_type, mem_addr, mem_din, mem_sign_ext  output  1/rw_type/32/32/1  drive the data memory.
REQ-015 mem_dout  input  32  the memory's combinational read data.

Function
REQ-016 A requester SHALL hold reqN and all its attributes stable until gntN; gntN is combinational in the same cycle.
REQ-017 At most one gntN SHALL be high per cycle; gnt0 and gnt1 are never both 1.
REQ-018 Single request: that port is granted immediately, whatever the priority pointer says.
REQ-019 Both requests: the port named by the priority pointer prio wins; after any grant, prio points to the other port (round robin).
REQ-020 The granted port's attributes SHALL be muxed onto the mem_* outputs in the grant cycle.
REQ-021 When no grant is issued, mem_write_en SHALL be 0 and the other mem_* outputs SHALL be 0.
REQ-022 Misalignment is an error: half with addr[0]=1, or word with addr[1:0]!=0.
REQ-023 Out-of-range is an error: addr + size - 1 >= MEM_SIZE, where size is 1, 2 or 4; the compare is done at 33 bits so there is no wrap.
REQ-024 An erroring request SHALL still be granted, with mem_write_en forced to 0; the next cycle gives rvalidN=1, rerrN=1 and rdataN=0.
REQ-025 Legal write: mem_write_en=1 in the grant cycle; the next cycle gives rvalidN=1, rerrN=0 and rdataN=0.
REQ-026 Legal read: mem_dout is captured at the grant-cycle edge; the next cycle gives rvalidN=1 and rdataN equal to the captured value.
REQ-027 rvalidN SHALL be a single-cycle pulse per grant; back-to-back grants to one port give back-to-back pulses.
REQ-028 rdataN and rerrN SHALL hold their last value while rvalidN=0.
REQ-029 A port may re-request in the cycle its rvalidN is high.

Reset
REQ-030 While rst=1, gnt0 and gnt1 SHALL be 0 and mem_write_en SHALL be 0; a request in the reset cycle is not granted.
REQ-031 On reset, prio SHALL be set to port 0, and rvalidN, rerrN and rdataN SHALL be set to 0.
REQ-032 The response due in the cycle after a grant SHALL be dropped (rvalidN=0) if rst is asserted in that cycle.

Structure
REQ-033 The rw_type enum (b=00, half=01, word=10) and a function returning the byte size of an rw_type SHALL live in the shared package mem_pkg, used by this block and by datamem.
REQ-034 The two-way round-robin pick (req0, req1, prio -> gnt0, gnt1, next prio) SHALL be a sub-module named rr_pick2; the alignment/range check stays in mem_arbiter.

Verification
REQ-035 After reset, req0=req1=1, both word reads of 0x10000 -> gnt0 in cycle 1 and gnt1 in cycle 2; rvalid0 in cycle 2 and rvalid1 in cycle 3.
REQ-036 Port 1 word write 0xDEADBEEF to 0x10004, then port 0 b read of 0x10007 with sext0=1 -> rdata0=0xFFFFFFDE, rerr0=0.
REQ-037 Port 0 half write to 0x10001 -> gnt0=1 and mem_write_en=0; next cycle rvalid0=1 and rerr0=1; the memory is unchanged.
REQ-038 Port 1 word read of 0x1FFFD with MEM_SIZE=0x20000 -> rerr1=1; the same access at 0x1FFFC -> rerr1=0.
REQ-039 Both ports request continuously for 10 cycles -> grants alternate 0,1,0,1,... with exactly 5 grants each and no double grant.
REQ-040 rst asserted in the cycle after a port 0 read grant -> rvalid0=0 in that cycle; prio=0 afterwards.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared access-size type and helpers for the data-memory path
//
// Contents:
//   rw_type           access size encoding (byte / half / word)
//   MEM_SIZE_DEFAULT  default byte size of the data memory
//   rw_size()         byte count of an rw_type (0 for the unused encoding)
package mem_pkg;

    typedef enum logic [1:0] {
        RW_B    = 2'b00,
        RW_HALF = 2'b01,
        RW_WORD = 2'b10
    } rw_type;

    localparam logic [31:0] MEM_SIZE_DEFAULT = 32'h0002_0000;

    // The unused encoding reports 0 so a caller can reject it as malformed.
    function automatic logic [2:0] rw_size(rw_type t);
        case (t)
            RW_B:    return 3'd1;
            RW_HALF: return 3'd2;
            RW_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick
//
// Ports:
//   req0_i, req1_i  qualified requests
//   prio_i          port that wins when both request (0 or 1)
//   gnt0_o, gnt1_o  one-hot-or-zero grant
//   prio_next_o     priority to use next cycle: the port that did not win,
//                   or prio_i unchanged when nothing was granted
module rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic prio_i,
    output logic gnt0_o,
    output logic gnt1_o,
    output logic prio_next_o
);

    always_comb begin
        gnt0_o      = 1'b0;
        gnt1_o      = 1'b0;
        prio_next_o = prio_i;

        if (req0_i && req1_i) begin
            gnt0_o = ~prio_i;
            gnt1_o = prio_i;
        end else begin
            // A lone requester wins regardless of the pointer.
            gnt0_o = req0_i;
            gnt1_o = req1_i;
        end

        if (gnt0_o) begin
            prio_next_o = 1'b1;
        end else if (gnt1_o) begin
            prio_next_o = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of the data memory
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN/weN/typeN/addrN     port N request (0 = LSU, 1 = DMA/debug); held
//   wdataN/sextN             stable by the requester until gntN
//   gntN                     combinational accept, same cycle as the request
//   rvalidN/rerrN/rdataN     response, one cycle after gntN
//   mem_write_en/mem_type/   granted access driven to the memory; all zero
//   mem_addr/mem_din/        when nothing is granted
//   mem_sign_ext
//   mem_dout                 memory's combinational read data
module mem_arbiter
    import mem_pkg::*;
#(
    parameter logic [31:0] MEM_SIZE = MEM_SIZE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0,
    input  logic        we0,
    input  rw_type      type0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        sext0,
    output logic        gnt0,
    output logic        rvalid0,
    output logic        rerr0,
    output logic [31:0] rdata0,

    input  logic        req1,
    input  logic        we1,
    input  rw_type      type1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic        sext1,
    output logic        gnt1,
    output logic        rvalid1,
    output logic        rerr1,
    output logic [31:0] rdata1,

    output logic        mem_write_en,
    output rw_type      mem_type,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_sign_ext,
    input  logic [31:0] mem_dout
);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic prio_q;
    logic prio_d;
    logic req0_v;
    logic req1_v;
    logic gnt0_c;
    logic gnt1_c;
    logic any_gnt;

    // Requests seen during reset are ignored so nothing reaches the memory.
    assign req0_v = req0 & ~rst;
    assign req1_v = req1 & ~rst;

    rr_pick2 u_pick (
        .req0_i      (req0_v),
        .req1_i      (req1_v),
        .prio_i      (prio_q),
        .gnt0_o      (gnt0_c),
        .gnt1_o      (gnt1_c),
        .prio_next_o (prio_d)
    );

    assign gnt0    = gnt0_c;
    assign gnt1    = gnt1_c;
    assign any_gnt = gnt0_c | gnt1_c;

    // ------------------------------------------------------------------
    // Granted-port attribute mux; everything reads as zero when idle
    // ------------------------------------------------------------------
    logic        sel_we;
    rw_type      sel_type;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_sext;

    always_comb begin
        sel_we    = 1'b0;
        sel_type  = RW_B;
        sel_addr  = 32'h0;
        sel_wdata = 32'h0;
        sel_sext  = 1'b0;
        if (gnt0_c) begin
            sel_we    = we0;
            sel_type  = type0;
            sel_addr  = addr0;
            sel_wdata = wdata0;
            sel_sext  = sext0;
        end else if (gnt1_c) begin
            sel_we    = we1;
            sel_type  = type1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
            sel_sext  = sext1;
        end
    end

    // ------------------------------------------------------------------
    // Alignment and range check on the granted access
    // ------------------------------------------------------------------
    logic [2:0]  sel_size;
    logic        misaligned;
    logic [32:0] last_byte;
    logic        out_of_range;
    logic        acc_err;

    assign sel_size = rw_size(sel_type);

    // The unused type encoding has size 0 and is treated like a misalignment.
    assign misaligned = ((sel_type == RW_HALF) && sel_addr[0])
                      || ((sel_type == RW_WORD) && (sel_addr[1:0] != 2'b00))
                      || (sel_size == 3'd0);

    // 33-bit sum so an access near 0xFFFFFFFF cannot wrap back into range.
    assign last_byte    = {1'b0, sel_addr} + {30'b0, sel_size} - 33'd1;
    assign out_of_range = (last_byte >= {1'b0, MEM_SIZE});
    assign acc_err      = misaligned | out_of_range;

    // ------------------------------------------------------------------
    // Memory side
    // ------------------------------------------------------------------
    assign mem_write_en = any_gnt & sel_we & ~acc_err;
    assign mem_type     = sel_type;
    assign mem_addr     = sel_addr;
    assign mem_din      = sel_wdata;
    assign mem_sign_ext = sel_sext;

    // Writes and rejected accesses return zero data.
    logic [31:0] rsp_data;
    assign rsp_data = (acc_err | sel_we) ? 32'h0 : mem_dout;

    // ------------------------------------------------------------------
    // Response registers; data and error only move on a grant so they
    // hold between pulses
    // ------------------------------------------------------------------
    logic        rvalid0_q;
    logic        rerr0_q;
    logic [31:0] rdata0_q;
    logic        rvalid1_q;
    logic        rerr1_q;
    logic [31:0] rdata1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rerr0_q   <= 1'b0;
            rdata0_q  <= 32'h0;
            rvalid1_q <= 1'b0;
            rerr1_q   <= 1'b0;
            rdata1_q  <= 32'h0;
        end else begin
            prio_q    <= prio_d;
            rvalid0_q <= gnt0_c;
            rvalid1_q <= gnt1_c;
            if (gnt0_c) begin
                rerr0_q  <= acc_err;
                rdata0_q <= rsp_data;
            end
            if (gnt1_c) begin
                rerr1_q  <= acc_err;
                rdata1_q <= rsp_data;
            end
        end
    end

    // A reset arriving in the response cycle drops that response at once,
    // and the outputs read as their reset values for the whole reset.
    assign rvalid0 = rvalid0_q & ~rst;
    assign rerr0   = rerr0_q & ~rst;
    assign rdata0  = rst ? 32'h0 : rdata0_q;
    assign rvalid1 = rvalid1_q & ~rst;
    assign rerr1   = rerr1_q & ~rst;
    assign rdata1  = rst ? 32'h0 : rdata1_q;

endmodule
